memory_game_ctrl: RTL and testbench

MEMORY_GAME_CTRL -- requirements
Module: memory_game_ctrl

---
 rtl/memory_game_ctrl.sv | 151 +++++++++++++++
 tb/tb_memory_game_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_game_ctrl.sv
// Memory (pairs) game controller: cursor navigation over the card grid, two-card pick,
// compare, timed face-down hold after a miss, and a DONE state once every pair is found.
module memory_game_ctrl #(
    parameter int unsigned GRID_X      = 5,
    parameter int unsigned GRID_Y      = 4,
    parameter int unsigned HOLD_FRAMES = 60
) (
    input  logic                         clock_50M,
    input  logic                         reset,
    input  logic                         frame_tick,
    input  logic                         right,
    input  logic                         left,
    input  logic                         up,
    input  logic                         down,
    input  logic                         select,
    input  logic [4*GRID_X*GRID_Y-1:0]   order,
    output logic [2:0]                   cursor_x,
    output logic [1:0]                   cursor_y,
    output logic [GRID_X*GRID_Y-1:0]     face_up,
    output logic [GRID_X*GRID_Y-1:0]     matched,
    output logic [3:0]                   pair_count,
    output logic [7:0]                   move_count,
    output logic                         game_over
);

    localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [2:0]    XMax      = 3'(GRID_X - 1);
    localparam logic [1:0]    YMax      = 2'(GRID_Y - 1);
    localparam logic [3:0]    NumPairs  = 4'(GRID_X * GRID_Y / 2);
    localparam logic [4:0]    Cols      = 5'(GRID_X);
    localparam logic [HW-1:0] HoldLoad  = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0] HoldLast  = HW'(1);

    typedef enum logic [2:0] {StPick1, StPick2, StCompare, StHold, StDone} state_t;

    state_t        state;
    logic [4:0]    first;
    logic [4:0]    second;
    logic [HW-1:0] hold_cnt;
    logic          right_prev, left_prev, up_prev, down_prev, select_prev;

    logic          right_edge, left_edge, up_edge, down_edge, select_edge;
    logic [4:0]    idx;

    assign right_edge  = right  & ~right_prev;
    assign left_edge   = left   & ~left_prev;
    assign up_edge     = up     & ~up_prev;
    assign down_edge   = down   & ~down_prev;
    assign select_edge = select & ~select_prev;
    assign idx         = 5'(cursor_y) * Cols + 5'(cursor_x);

    always_ff @(posedge clock_50M or posedge reset) begin
        if (reset) begin
            state       <= StPick1;
            cursor_x    <= '0;
            cursor_y    <= '0;
            face_up     <= '0;
            matched     <= '0;
            pair_count  <= '0;
            move_count  <= '0;
            game_over   <= 1'b0;
            first       <= '0;
            second      <= '0;
            hold_cnt    <= '0;
            // Held-high buttons across reset release must not look like fresh presses.
            right_prev  <= 1'b1;
            left_prev   <= 1'b1;
            up_prev     <= 1'b1;
            down_prev   <= 1'b1;
            select_prev <= 1'b1;
        end else begin
            right_prev  <= right;
            left_prev   <= left;
            up_prev     <= up;
            down_prev   <= down;
            select_prev <= select;

            if (state != StDone) begin
                if (right_edge && !left_edge && cursor_x != XMax) begin
                    cursor_x <= cursor_x + 3'd1;
                end else if (left_edge && !right_edge && cursor_x != 3'd0) begin
                    cursor_x <= cursor_x - 3'd1;
                end
                if (down_edge && !up_edge && cursor_y != YMax) begin
                    cursor_y <= cursor_y + 2'd1;
                end else if (up_edge && !down_edge && cursor_y != 2'd0) begin
                    cursor_y <= cursor_y - 2'd1;
                end
            end

            unique case (state)
                StPick1: begin
                    if (select_edge && !face_up[idx]) begin
                        face_up[idx] <= 1'b1;
                        first        <= idx;
                        state        <= StPick2;
                    end
                end
                StPick2: begin
                    if (select_edge && !face_up[idx]) begin
                        face_up[idx] <= 1'b1;
                        second       <= idx;
                        if (move_count != 8'hFF) move_count <= move_count + 8'd1;
                        state        <= StCompare;
                    end
                end
                StCompare: begin
                    if (order[{first, 2'b00} +: 4] == order[{second, 2'b00} +: 4]) begin
                        matched[first]  <= 1'b1;
                        matched[second] <= 1'b1;
                        pair_count      <= pair_count + 4'd1;
                        if (pair_count + 4'd1 == NumPairs) begin
                            game_over <= 1'b1;
                            state     <= StDone;
                        end else begin
                            state <= StPick1;
                        end
                    end else begin
                        hold_cnt <= HoldLoad;
                        state    <= StHold;
                    end
                end
                StHold: begin
                    if (frame_tick) begin
                        if (hold_cnt <= HoldLast) begin
                            hold_cnt        <= '0;
                            face_up[first]  <= 1'b0;
                            face_up[second] <= 1'b0;
                            state           <= StPick1;
                        end else begin
                            hold_cnt <= hold_cnt - HoldLast;
                        end
                    end
                end
                StDone: begin
                    if (select_edge) begin
                        face_up    <= '0;
                        matched    <= '0;
                        pair_count <= '0;
                        move_count <= '0;
                        game_over  <= 1'b0;
                        state      <= StPick1;
                    end
                end
                default: state <= StPick1;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl: cursor limits, match, mismatch hold, full game, reset.
module tb_memory_game_ctrl;

    localparam logic [4:0] BR = 5'b00001;
    localparam logic [4:0] BL = 5'b00010;
    localparam logic [4:0] BU = 5'b00100;
    localparam logic [4:0] BD = 5'b01000;
    localparam logic [4:0] BS = 5'b10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ft;
    logic [4:0]  btn;
    logic [79:0] order;
    logic [2:0]  cursor_x;
    logic [1:0]  cursor_y;
    logic [19:0] face_up;
    logic [19:0] matched;
    logic [3:0]  pair_count;
    logic [7:0]  move_count;
    logic        game_over;

    int n_total = 0;
    int n_pass  = 0;

    memory_game_ctrl #(
        .GRID_X      (5),
        .GRID_Y      (4),
        .HOLD_FRAMES (3)
    ) dut (
        .clock_50M  (clk),
        .reset      (rst),
        .frame_tick (ft),
        .right      (btn[0]),
        .left       (btn[1]),
        .up         (btn[2]),
        .down       (btn[3]),
        .select     (btn[4]),
        .order      (order),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .face_up    (face_up),
        .matched    (matched),
        .pair_count (pair_count),
        .move_count (move_count),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        btn = b;
        tick();
        btn = '0;
        tick();
    endtask

    task automatic frame();
        ft = 1'b1;
        tick();
        ft = 1'b0;
        tick();
    endtask

    task automatic sel_card(input int c);
        repeat (4) press(BL);
        repeat (3) press(BU);
        repeat (c % 5) press(BR);
        repeat (c / 5) press(BD);
        press(BS);
    endtask

    initial begin
        rst = 1'b1;
        ft  = 1'b0;
        btn = '0;
        // Cards 2k and 2k+1 form pair (k+3)%10, so cards 0/1 are pair 3 and card 2 is pair 4.
        for (int k = 0; k < 10; k++) begin
            order[8*k +: 4]     = 4'((k + 3) % 10);
            order[8*k + 4 +: 4] = 4'((k + 3) % 10);
        end
        tick();
        tick();
        check("rst_cx", 32'(cursor_x), 0);
        check("rst_fu", 32'(face_up), 0);
        check("rst_go", 32'(game_over), 0);
        rst = 1'b0;
        tick();

        // Cursor saturation and conflicting edges
        repeat (6) press(BR);
        check("cx_sat_right", 32'(cursor_x), 4);
        repeat (5) press(BD);
        check("cy_sat_down", 32'(cursor_y), 3);
        press(BL | BR);
        check("cx_lr_at_max", 32'(cursor_x), 4);
        press(BL);
        check("cx_left", 32'(cursor_x), 3);
        press(BL | BR);
        check("cx_lr_mid", 32'(cursor_x), 3);
        press(BU | BD | BL);
        check("cx_x_with_ud", 32'(cursor_x), 2);
        check("cy_ud_ignored", 32'(cursor_y), 3);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("cx_after_rst", 32'(cursor_x), 0);
        check("cy_after_rst", 32'(cursor_y), 0);

        // Double-select of card 0, then mismatch against card 2
        press(BS);
        check("pick1_fu", 32'(face_up), 20'h00001);
        press(BS);
        check("dbl_sel_mc", 32'(move_count), 0);
        check("dbl_sel_fu", 32'(face_up), 20'h00001);
        press(BR);
        press(BR);
        press(BS);
        check("miss_mc", 32'(move_count), 1);
        check("miss_fu", 32'(face_up), 20'h00005);
        check("miss_matched", 32'(matched), 0);
        frame();
        check("hold_f1", 32'(face_up), 20'h00005);
        press(BS);
        check("hold_sel_fu", 32'(face_up), 20'h00005);
        check("hold_sel_mc", 32'(move_count), 1);
        frame();
        check("hold_f2", 32'(face_up), 20'h00005);
        frame();
        check("hold_f3", 32'(face_up), 20'h00000);

        // Match cards 0 and 1
        press(BL);
        press(BL);
        press(BS);
        press(BR);
        press(BS);
        check("hit_matched", 32'(matched), 20'h00003);
        check("hit_pc", 32'(pair_count), 1);
        check("hit_mc", 32'(move_count), 2);
        check("hit_fu", 32'(face_up), 20'h00003);
        // Back in PICK1: selecting a face-up card does nothing, a fresh card does not count a move
        press(BS);
        press(BR);
        press(BS);
        check("pick1_again_fu", 32'(face_up), 20'h00007);
        check("pick1_again_mc", 32'(move_count), 2);
        press(BR);
        press(BS);
        check("hit2_pc", 32'(pair_count), 2);
        check("hit2_mc", 32'(move_count), 3);

        // Solve the rest
        for (int k = 2; k < 10; k++) begin
            sel_card(2 * k);
            sel_card(2 * k + 1);
            check($sformatf("solve_pc_%0d", k), 32'(pair_count), 32'(k + 1));
        end
        check("done_go", 32'(game_over), 1);
        check("done_fu", 32'(face_up), 20'hFFFFF);
        check("done_matched", 32'(matched), 20'hFFFFF);
        check("done_mc", 32'(move_count), 11);
        press(BL);
        press(BU);
        check("done_cx_frozen", 32'(cursor_x), 4);
        check("done_cy_frozen", 32'(cursor_y), 3);
        press(BS);
        check("restart_go", 32'(game_over), 0);
        check("restart_pc", 32'(pair_count), 0);
        check("restart_mc", 32'(move_count), 0);
        check("restart_fu", 32'(face_up), 0);
        check("restart_matched", 32'(matched), 0);
        check("restart_cx", 32'(cursor_x), 4);

        // Asynchronous reset mid-HOLD
        sel_card(0);
        sel_card(2);
        frame();
        check("pre_rst_fu", 32'(face_up), 20'h00005);
        #2;
        rst = 1'b1;
        #1;
        check("arst_fu", 32'(face_up), 0);
        check("arst_mc", 32'(move_count), 0);
        check("arst_cx", 32'(cursor_x), 0);
        check("arst_cy", 32'(cursor_y), 0);
        check("arst_go", 32'(game_over), 0);
        check("arst_pc", 32'(pair_count), 0);
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
